// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// pipeline_hazard_ctrl_pkg
// Shared types, constants and control-word bit layout for decoder and interlock.
// Revision: 1.0
// ============================================================================
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } hz_state_e;

  localparam int REG_ZERO = 0;

  // Decoder control-word bit positions feeding the hazard inputs
  localparam int CTL_USES_RS    = 0;
  localparam int CTL_USES_RT    = 1;
  localparam int CTL_IS_MULDIV  = 2;
  localparam int CTL_READS_HILO = 3;
  localparam int CTL_MEM_READ   = 4;
  localparam int CTL_W          = 5;

  typedef struct packed {
    logic uses_rs;
    logic uses_rt;
    logic is_muldiv;
    logic reads_hilo;
    logic mem_read;
  } ctl_bits_t;

  function automatic ctl_bits_t decode_ctl(input logic [CTL_W-1:0] ctl);
    ctl_bits_t b;
    b.uses_rs    = ctl[CTL_USES_RS];
    b.uses_rt    = ctl[CTL_USES_RT];
    b.is_muldiv  = ctl[CTL_IS_MULDIV];
    b.reads_hilo = ctl[CTL_READS_HILO];
    b.mem_read   = ctl[CTL_MEM_READ];
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// pipeline_hazard_ctrl_if
// Decode/EX hazard inputs and interlock outputs of the hazard controller.
// Revision: 1.0
// ============================================================================
interface pipeline_hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             id_is_muldiv;
  logic             id_reads_hilo;
  logic             ex_valid;
  logic             ex_mem_read;
  logic [REG_W-1:0] ex_dst;
  logic             branch_taken;
  logic             if_hold;
  logic             id_hold;
  logic             ex_bubble;
  logic             flush;
  logic             muldiv_start;
  logic             muldiv_busy;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_muldiv,
           id_reads_hilo, ex_valid, ex_mem_read, ex_dst, branch_taken,
    input  if_hold, id_hold, ex_bubble, flush, muldiv_start, muldiv_busy,
           stall_cycles
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_muldiv,
           id_reads_hilo, ex_valid, ex_mem_read, ex_dst, branch_taken,
    output if_hold, id_hold, ex_bubble, flush, muldiv_start, muldiv_busy,
           stall_cycles
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_muldiv_busy_timer.sv
`default_nettype none
// ============================================================================
// muldiv_busy_timer
// Tracks mul/div occupancy: busy for MULDIV_LAT-1 cycles after a start pulse.
// Revision: 1.0
// ============================================================================
module muldiv_busy_timer
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MULDIV_LAT = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy
);

  localparam logic [7:0] C_LOAD = 8'(MULDIV_LAT - 1);

  hz_state_e  r_state;
  hz_state_e  w_state_nxt;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Once launched the unit cannot be aborted, so nothing but reset exits MD_BUSY early
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      RUN: begin
        if (start) begin
          w_state_nxt = MD_BUSY;
          w_cnt_nxt   = C_LOAD;
        end
      end
      MD_BUSY: begin
        w_cnt_nxt = r_cnt - 8'd1;
        if (r_cnt == 8'd1) begin
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  assign busy = (r_state == MD_BUSY);

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// pipeline_hazard_ctrl
// Decode-stage interlock: load-use and mul/div stalls, EX bubbles, redirect flush.
// Revision: 1.0
// ============================================================================
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MULDIV_LAT = 32,
  parameter int REG_W      = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipeline_hazard_ctrl_if.slave hz
);

  logic             r_run_en;
  logic             r_flush_q;
  logic [CNT_W-1:0] r_stall_cycles;

  logic w_id_live;
  logic w_branch;
  logic w_rs_hit;
  logic w_rt_hit;
  logic w_lu;
  logic w_sh;
  logic w_flush;
  logic w_hold;
  logic w_start;
  logic w_busy;

  // r_run_en keeps every output quiet through reset and the first cycle after release
  assign w_id_live = hz.id_valid & r_run_en;
  assign w_branch  = hz.branch_taken & r_run_en;

  assign w_rs_hit = hz.id_uses_rs & (hz.id_rs == hz.ex_dst);
  assign w_rt_hit = hz.id_uses_rt & (hz.id_rt == hz.ex_dst);
  assign w_lu     = w_id_live & hz.ex_valid & hz.ex_mem_read &
                    (hz.ex_dst != REG_W'(REG_ZERO)) & (w_rs_hit | w_rt_hit);
  assign w_sh     = w_id_live & w_busy & (hz.id_is_muldiv | hz.id_reads_hilo);

  // Control word lags the instruction by one cycle, hence the second flush slot
  assign w_flush = w_branch | r_flush_q;
  assign w_hold  = ~w_flush & (w_sh | w_lu);
  assign w_start = w_id_live & hz.id_is_muldiv & ~w_flush & ~w_lu & ~w_busy;

  muldiv_busy_timer #(
    .MULDIV_LAT (MULDIV_LAT)
  ) u_muldiv_busy_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .start (w_start),
    .busy  (w_busy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run_en       <= 1'b0;
      r_flush_q      <= 1'b0;
      r_stall_cycles <= '0;
    end else begin
      r_run_en  <= 1'b1;
      r_flush_q <= w_branch;
      if (w_hold && (r_stall_cycles != {CNT_W{1'b1}})) begin
        r_stall_cycles <= r_stall_cycles + 1'b1;
      end
    end
  end

  assign hz.if_hold      = w_hold;
  assign hz.id_hold      = w_hold;
  assign hz.ex_bubble    = w_flush | w_hold;
  assign hz.flush        = w_flush;
  assign hz.muldiv_start = w_start;
  assign hz.muldiv_busy  = w_busy;
  assign hz.stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pipeline_hazard_ctrl
// Scoreboard bench for the decode-stage hazard controller.
// Revision: 1.0
// ============================================================================
module tb_pipeline_hazard_ctrl;
  import pipeline_hazard_ctrl_pkg::*;

  localparam int LAT   = 4;
  localparam int REG_W = 5;
  localparam int CNT_W = 16;

  localparam logic [CTL_W-1:0] K_NONE = '0;
  localparam logic [CTL_W-1:0] K_RS   = CTL_W'(1) << CTL_USES_RS;
  localparam logic [CTL_W-1:0] K_RT   = CTL_W'(1) << CTL_USES_RT;
  localparam logic [CTL_W-1:0] K_MD   = CTL_W'(1) << CTL_IS_MULDIV;
  localparam logic [CTL_W-1:0] K_HILO = CTL_W'(1) << CTL_READS_HILO;

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [CTL_W-1:0] ctl;
    logic             exv;
    logic             ld;
    logic [REG_W-1:0] dst;
    logic             bt;
  } stim_t;

  typedef struct packed {
    logic             if_hold;
    logic             id_hold;
    logic             ex_bubble;
    logic             flush;
    logic             start;
    logic             busy;
    logic [CNT_W-1:0] stall;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) hz_if();

  pipeline_hazard_ctrl #(
    .MULDIV_LAT (LAT),
    .REG_W      (REG_W),
    .CNT_W      (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz_if)
  );

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb_q[$];

  // Reference model state
  logic             m_run_en;
  logic             m_flush_q;
  int               m_busy_left;
  logic [CNT_W-1:0] m_stall;
  logic             m_start;
  logic             m_hold;
  logic             m_bt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic stim_t mk(input logic v, input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                               input logic [CTL_W-1:0] ctl, input logic exv, input logic ld,
                               input logic [REG_W-1:0] dst, input logic bt);
    stim_t s;
    s.v = v; s.rs = rs; s.rt = rt; s.ctl = ctl;
    s.exv = exv; s.ld = ld; s.dst = dst; s.bt = bt;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    ctl_bits_t b;
    b = decode_ctl(s.ctl);
    hz_if.id_valid      = s.v;
    hz_if.id_rs         = s.rs;
    hz_if.id_rt         = s.rt;
    hz_if.id_uses_rs    = b.uses_rs;
    hz_if.id_uses_rt    = b.uses_rt;
    hz_if.id_is_muldiv  = b.is_muldiv;
    hz_if.id_reads_hilo = b.reads_hilo;
    hz_if.ex_valid      = s.exv;
    hz_if.ex_mem_read   = s.ld;
    hz_if.ex_dst        = s.dst;
    hz_if.branch_taken  = s.bt;
  endtask

  task automatic model_reset();
    m_run_en    = 1'b0;
    m_flush_q   = 1'b0;
    m_busy_left = 0;
    m_stall     = '0;
  endtask

  task automatic model_eval(input stim_t s, output exp_t e);
    ctl_bits_t b;
    logic live, lu, sh, fl, busy;
    b    = decode_ctl(s.ctl);
    live = s.v & m_run_en;
    busy = (m_busy_left > 0);
    lu   = live & s.exv & s.ld & (s.dst != '0) &
           ((b.uses_rs & (s.rs == s.dst)) | (b.uses_rt & (s.rt == s.dst)));
    sh   = live & busy & (b.is_muldiv | b.reads_hilo);
    fl   = (s.bt & m_run_en) | m_flush_q;
    e.flush     = fl;
    e.if_hold   = !fl && (sh || lu);
    e.id_hold   = e.if_hold;
    e.ex_bubble = fl || sh || lu;
    e.start     = live & b.is_muldiv & ~fl & ~lu & ~busy;
    e.busy      = busy;
    e.stall     = m_stall;
    m_start = e.start;
    m_hold  = e.if_hold;
    m_bt    = s.bt & m_run_en;
  endtask

  task automatic model_advance();
    m_flush_q = m_bt;
    if (m_start)              m_busy_left = LAT - 1;
    else if (m_busy_left > 0) m_busy_left = m_busy_left - 1;
    if (m_hold && m_stall != {CNT_W{1'b1}}) m_stall = m_stall + 1'b1;
    m_run_en = 1'b1;
  endtask

  task automatic compare_outputs(input exp_t e);
    check("if_hold",      32'(hz_if.if_hold),      32'(e.if_hold));
    check("id_hold",      32'(hz_if.id_hold),      32'(e.id_hold));
    check("ex_bubble",    32'(hz_if.ex_bubble),    32'(e.ex_bubble));
    check("flush",        32'(hz_if.flush),        32'(e.flush));
    check("muldiv_start", 32'(hz_if.muldiv_start), 32'(e.start));
    check("muldiv_busy",  32'(hz_if.muldiv_busy),  32'(e.busy));
    check("stall_cycles", 32'(hz_if.stall_cycles), 32'(e.stall));
  endtask

  // Called just after a falling edge; returns just after the next falling edge
  task automatic cycle(input stim_t s);
    exp_t e;
    drive(s);
    model_eval(s, e);
    sb_q.push_back(e);
    #2;
    if (sb_q.size() == 0) check("scoreboard_empty", 32'd1, 32'd0);
    else                  compare_outputs(sb_q.pop_front());
    @(posedge clk);
    model_advance();
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, {26'd0, hz_if.if_hold, hz_if.id_hold, hz_if.ex_bubble,
                           hz_if.flush, hz_if.muldiv_start, hz_if.muldiv_busy}, 32'd0);
    check({tag, "_stall"}, 32'(hz_if.stall_cycles), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    stim_t nop, lu5;
    nop = mk(1'b0, 5'd0, 5'd0, K_NONE, 1'b0, 1'b0, 5'd0, 1'b0);
    lu5 = mk(1'b1, 5'd5, 5'd0, K_RS, 1'b1, 1'b1, 5'd5, 1'b0);
    model_reset();

    // Reset with a hazard and redirect present: outputs must stay low
    drive(mk(1'b1, 5'd5, 5'd0, K_RS | K_MD, 1'b1, 1'b1, 5'd5, 1'b1));
    #7;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    // First cycle after release: still quiet
    cycle(mk(1'b1, 5'd5, 5'd0, K_RS | K_MD, 1'b1, 1'b1, 5'd5, 1'b1));
    cycle(nop);
    cycle(nop);

    // Load-use
    cycle(lu5);
    cycle(mk(1'b1, 5'd5, 5'd0, K_RS, 1'b1, 1'b0, 5'd7, 1'b0));
    cycle(mk(1'b1, 5'd0, 5'd0, K_RS, 1'b1, 1'b1, 5'd0, 1'b0));
    cycle(mk(1'b1, 5'd1, 5'd9, K_RT, 1'b1, 1'b1, 5'd9, 1'b0));
    cycle(mk(1'b1, 5'd9, 5'd1, K_RT, 1'b1, 1'b1, 5'd9, 1'b0));
    cycle(mk(1'b0, 5'd5, 5'd5, K_RS | K_RT, 1'b1, 1'b1, 5'd5, 1'b0));
    cycle(mk(1'b1, 5'd5, 5'd5, K_RS | K_RT, 1'b0, 1'b1, 5'd5, 1'b0));

    // mul/div then mfhi: three stall cycles, then issue
    cycle(mk(1'b1, 5'd2, 5'd3, K_MD | K_RS | K_RT, 1'b0, 1'b0, 5'd0, 1'b0));
    for (int i = 0; i < 4; i++) cycle(mk(1'b1, 5'd0, 5'd0, K_HILO, 1'b0, 1'b0, 5'd0, 1'b0));
    cycle(nop);

    // Redirect over a load-use hazard; then back-to-back redirects
    cycle(mk(1'b1, 5'd5, 5'd0, K_RS, 1'b1, 1'b1, 5'd5, 1'b1));
    cycle(lu5);
    cycle(lu5);
    cycle(mk(1'b0, 5'd0, 5'd0, K_NONE, 1'b0, 1'b0, 5'd0, 1'b1));
    cycle(mk(1'b0, 5'd0, 5'd0, K_NONE, 1'b0, 1'b0, 5'd0, 1'b1));
    cycle(nop);
    cycle(nop);

    // Redirect with mul/div in decode; then flush during MD_BUSY
    cycle(mk(1'b1, 5'd0, 5'd0, K_MD, 1'b0, 1'b0, 5'd0, 1'b1));
    cycle(mk(1'b1, 5'd0, 5'd0, K_MD, 1'b0, 1'b0, 5'd0, 1'b0));
    cycle(mk(1'b1, 5'd0, 5'd0, K_MD, 1'b0, 1'b0, 5'd0, 1'b0));
    cycle(mk(1'b0, 5'd0, 5'd0, K_NONE, 1'b0, 1'b0, 5'd0, 1'b1));
    // mul/div waits out the busy window and starts on the return to RUN
    for (int i = 0; i < 4; i++) cycle(mk(1'b1, 5'd0, 5'd0, K_MD, 1'b0, 1'b0, 5'd0, 1'b0));
    cycle(nop);
    cycle(nop);
    cycle(nop);

    // Async reset mid-MD_BUSY with flush_q set
    cycle(mk(1'b1, 5'd0, 5'd0, K_MD, 1'b0, 1'b0, 5'd0, 1'b0));
    cycle(mk(1'b0, 5'd0, 5'd0, K_NONE, 1'b0, 1'b0, 5'd0, 1'b1));
    drive(mk(1'b1, 5'd5, 5'd0, K_RS | K_HILO, 1'b1, 1'b1, 5'd5, 1'b1));
    #1;
    check("pre_reset_busy",  32'(hz_if.muldiv_busy), 32'd1);
    check("pre_reset_flush", 32'(hz_if.flush),       32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(mk(1'b1, 5'd0, 5'd0, K_HILO, 1'b0, 1'b0, 5'd0, 1'b0));
    cycle(mk(1'b1, 5'd0, 5'd0, K_HILO, 1'b0, 1'b0, 5'd0, 1'b0));

    // Saturation of the stall counter
    for (int i = 0; i < (1 << CNT_W) + 5; i++) cycle(lu5);
    check("stall_saturated", 32'(hz_if.stall_cycles), 32'h0000_FFFF);
    cycle(nop);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Interlock and scheduler for the decode stage: stalls fetch/decode, injects EX bubbles and flushes the front end.
- Covers load-use hazards, the multi-cycle mul/div unit, and taken-branch redirects.
- Sits beside the microcode decoder; its hazard inputs are decoded control-signal bits.
- The decoder's control word appears one cycle after the instruction word, so a redirect must kill two front-end slots.

Parameters:
- MULDIV_LAT, 32: cycles the mul/div unit stays busy after a start; legal 2..255.
- REG_W, 5: register-index width.
- CNT_W, 16: stall performance-counter width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  decode stage holds a live instruction.
- id_rs  in  REG_W  source register rs of the decode instruction.
- id_rt  in  REG_W  source register rt of the decode instruction.
- id_uses_rs  in  1  decode instruction reads rs.
- id_uses_rt  in  1  decode instruction reads rt.
- id_is_muldiv  in  1  decode instruction is mult/div.
- id_reads_hilo  in  1  decode instruction is mfhi/mflo.
- ex_valid  in  1  EX stage holds a live instruction.
- ex_mem_read  in  1  EX instruction is a load.
- ex_dst  in  REG_W  EX destination register.
- branch_taken  in  1  EX resolved a taken branch/jump this cycle.
- if_hold  out  1  fetch holds its PC and instruction.
- id_hold  out  1  decode holds its instruction.
- ex_bubble  out  1  EX latches a NOP instead of the decode output.
- flush  out  1  kill IF and ID contents.
- muldiv_start  out  1  one-cycle launch pulse to the mul/div unit.
- muldiv_busy  out  1  mul/div unit occupied.
- stall_cycles  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Reset (async, rst_n=0): state=RUN, counter=0, flush_q=0, stall_cycles=0.
  - All outputs are 0 during reset and on the first cycle after release.
- Load-use hazard (combinational):
  - lu = id_valid & ex_valid & ex_mem_read & (ex_dst!=0) & ((id_uses_rs & id_rs==ex_dst) | (id_uses_rt & id_rt==ex_dst)).
- Structural hazard (combinational):
  - sh = id_valid & (state==MD_BUSY) & (id_is_muldiv | id_reads_hilo).
- flush = branch_taken | flush_q.
  - flush_q <= branch_taken, giving exactly 2 flush cycles per redirect.
  - A redirect on consecutive cycles extends flush accordingly.
- Priority: flush > sh > lu.
  - During flush: if_hold=id_hold=0, ex_bubble=1, muldiv_start=0.
  - Else if sh|lu: if_hold=id_hold=ex_bubble=1.
  - Otherwise all three are 0.
- muldiv_start = id_valid & id_is_muldiv & ~flush & ~lu & (state==RUN).
- FSM states:
  - RUN: on muldiv_start, load counter=MULDIV_LAT-1 and go to MD_BUSY.
  - MD_BUSY: counter decrements each cycle; when counter==1, next state is RUN. Total busy = MULDIV_LAT-1 cycles after the start cycle.
- muldiv_busy = (state==MD_BUSY), registered.
- flush does NOT cancel MD_BUSY; the unit cannot be aborted, so the counter runs to completion.
- A mul/div or mfhi in decode on the cycle the FSM returns to RUN proceeds without stalling; mul/div starts a new run.
- stall_cycles increments on every cycle with id_hold=1 and saturates at all-ones.
  - Flush cycles are not counted.
- Register 0 never creates a hazard.
- Any hazard is ignored when id_valid=0.

Decomposition:
- Shared package:
  - state enum {RUN, MD_BUSY};
  - REG_ZERO constant;
  - control-signal bit indices that drive id_uses_rs, id_uses_rt, id_is_muldiv, id_reads_hilo, ex_mem_read, so that decoder and controller agree.
- One sub-module: muldiv_busy_timer, holding the FSM plus down-counter.
  - Inputs: start. Outputs: busy. Parameter: MULDIV_LAT.

Test Plan:
1. Load to r5 in EX, decode uses rs=5 -> one cycle with if_hold=id_hold=ex_bubble=1, stall_cycles=1. Same with ex_dst=0 -> no stall.
2. id_is_muldiv, MULDIV_LAT=4 -> muldiv_start pulse, muldiv_busy high 3 cycles. mfhi arriving next cycle stalls 3 cycles, then issues.
3. branch_taken for 1 cycle while a load-use hazard is present -> flush=1 for 2 cycles, ex_bubble=1, if_hold=0, stall_cycles unchanged.
4. branch_taken on the same cycle a mul/div is in decode -> muldiv_start=0, FSM stays RUN. Flush during MD_BUSY -> busy still lasts its full length.
5. Force 2^CNT_W+5 stall cycles -> stall_cycles saturates at 0xFFFF.
6. Assert rst_n=0 mid-MD_BUSY with flush_q=1 -> all outputs 0 immediately (asynchronously). After release, state is RUN and no stall occurs.
